// File: rtl/regfile_pkg.sv
// Shared constants for the integer-pipeline register file.
// The optional write-to-read forwarding is selected with the REGFILE_BYPASS_EN
// macro; see regfile_rd_port.
package regfile_pkg;

    localparam int REG_BUS_W    = 32;             // width of a register word
    localparam int REG_ADDR_W   = 5;              // width of a register address
    localparam int REG_NUM      = 32;             // architectural registers
    localparam int REG_NUM_LOG2 = 5;

    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    localparam logic [REG_BUS_W-1:0]  ZERO_DWORD   = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    // Number of read ports on the file.
    localparam int NUM_RD = 2;

endpackage

// File: rtl/regfile_if.sv
// Register file bus: one write-back port and two decode read ports.
// master = pipeline side, slave = register file side.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
// Priority: reset, port disabled, register 0, write bypass (only when
// REGFILE_BYPASS_EN is defined), stored array word.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] rword_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

`ifndef REGFILE_BYPASS_EN
    // Write-side inputs only matter for forwarding; keep them visibly consumed.
    logic unused_wr;
    assign unused_wr = ^{we_i, waddr_i, wdata_i};
`endif

    // Read priority mux; register 0 is excluded before the bypass is considered.
    always_comb begin
        rdata_o = '0;
        if (rst_i == RST_ENABLE) begin
            rdata_o = '0;
        end else if (re_i != READ_ENABLE) begin
            rdata_o = '0;
        end else if (raddr_i == '0) begin
            rdata_o = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (we_i == WRITE_ENABLE && raddr_i == waddr_i) begin
            rdata_o = wdata_i;
`endif
        end else begin
            rdata_o = rword_i;
        end
    end

endmodule

// File: rtl/regfile.sv
// General-purpose register file: one synchronous write port, two
// combinational read ports, register 0 hardwired to zero.
// Build option REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int REG_NUM = 2**ADDR_W
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    logic [REG_NUM-1:0][DATA_W-1:0] regs_q, regs_d;

    logic [NUM_RD-1:0]             re_v;
    logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
    logic [NUM_RD-1:0][DATA_W-1:0] rword_v;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;

    // Next array state: reset clears everything and drops any write; entry 0 stays zero.
    always_comb begin
        regs_d = regs_q;
        if (rst == RST_ENABLE) begin
            regs_d = '0;
        end else if (bus.we == WRITE_ENABLE && bus.waddr != '0) begin
            regs_d[bus.waddr] = bus.wdata;
        end
        regs_d[0] = '0;
    end

    // Storage array update.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign re_v    = {bus.re2, bus.re1};
    assign raddr_v = {bus.raddr2, bus.raddr1};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rword_v[p] = regs_q[raddr_v[p]];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .rst_i   (rst),
            .re_i    (re_v[p]),
            .raddr_i (raddr_v[p]),
            .rword_i (rword_v[p]),
            .we_i    (bus.we),
            .waddr_i (bus.waddr),
            .wdata_i (bus.wdata),
            .rdata_o (rdata_v[p])
        );
    end

    assign bus.rdata1 = rdata_v[0];
    assign bus.rdata2 = rdata_v[1];

endmodule

// File: tb/tb_regfile.sv
// Directed scoreboard bench for regfile. Stimulus pushes expected read data
// and raises a sample strobe; a monitor on the falling edge pops and compares.
module tb_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_if #(.DATA_W(32), .ADDR_W(5)) rf_if ();

    regfile #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t exp_q[$];
    logic smp_vld = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Monitor: compare both read ports whenever a sample is presented.
    always @(negedge clk) begin
        if (smp_vld) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard_empty: sample with no expected entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_chk++;
                if (rf_if.rdata1 === e.e1) n_pass++;
                else $display("FAIL %s rdata1: got %08h want %08h", e.name, rf_if.rdata1, e.e1);
                n_chk++;
                if (rf_if.rdata2 === e.e2) n_pass++;
                else $display("FAIL %s rdata2: got %08h want %08h", e.name, rf_if.rdata2, e.e2);
            end
        end
    end

    // One clock cycle of stimulus; optionally queue an expectation for it.
    task automatic cyc(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2,
                       input bit chk, input string nm,
                       input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        rf_if.we     = we;
        rf_if.waddr  = wa;
        rf_if.wdata  = wd;
        rf_if.re1    = re1;
        rf_if.raddr1 = ra1;
        rf_if.re2    = re2;
        rf_if.raddr2 = ra2;
        if (chk) begin
            e.name = nm; e.e1 = e1; e.e2 = e2;
            exp_q.push_back(e);
        end
        smp_vld = chk;
    endtask

    initial begin
        rst = 1'b1;
        rf_if.we = 1'b0; rf_if.waddr = '0; rf_if.wdata = '0;
        rf_if.re1 = 1'b0; rf_if.raddr1 = '0; rf_if.re2 = 1'b0; rf_if.raddr2 = '0;

        //   rst we wa  wdata         re1 ra1 re2 ra2 chk name            e1            e2
        cyc(1, 0, 0,  32'h0,         1,  5,  1,  7,  1, "rst_read",      32'h0,        32'h0);
        cyc(1, 1, 12, 32'h55,        1,  12, 1,  31, 1, "rst_write",     32'h0,        32'h0);
        cyc(0, 0, 0,  32'h0,         1,  12, 1,  12, 1, "wr_during_rst", 32'h0,        32'h0);
        cyc(0, 1, 5,  32'hDEADBEEF,  0,  5,  0,  5,  1, "re_off",        32'h0,        32'h0);
        cyc(0, 0, 0,  32'h0,         1,  5,  1,  5,  1, "r5_written",    32'hDEADBEEF, 32'hDEADBEEF);
        cyc(1, 0, 0,  32'h0,         1,  5,  1,  5,  1, "rst_comb_zero", 32'h0,        32'h0);
        cyc(0, 0, 0,  32'h0,         1,  5,  1,  5,  1, "rst_clears_r5", 32'h0,        32'h0);
        cyc(0, 1, 7,  32'h12345678,  0,  0,  0,  0,  0, "",              32'h0,        32'h0);
        cyc(0, 0, 0,  32'h0,         1,  7,  0,  7,  1, "r7_basic",      32'h12345678, 32'h0);
        cyc(0, 1, 0,  32'hFFFFFFFF,  1,  0,  1,  0,  1, "r0_wr_cycle",   32'h0,        32'h0);
        cyc(0, 0, 0,  32'h0,         1,  0,  1,  0,  1, "r0_zero",       32'h0,        32'h0);
        cyc(0, 1, 9,  32'h11111111,  0,  0,  0,  0,  0, "",              32'h0,        32'h0);
        cyc(0, 1, 9,  32'h22222222,  1,  9,  1,  9,  1, "r9_same_cycle",
            BYP ? 32'h22222222 : 32'h11111111, BYP ? 32'h22222222 : 32'h11111111);
        cyc(0, 0, 0,  32'h0,         1,  9,  1,  9,  1, "r9_after",      32'h22222222, 32'h22222222);
        cyc(0, 1, 3,  32'hA,         0,  0,  0,  0,  0, "",              32'h0,        32'h0);
        cyc(0, 1, 4,  32'hB,         1,  3,  1,  4,  1, "r4_same_cycle", 32'hA,        BYP ? 32'hB : 32'h0);
        cyc(0, 0, 0,  32'h0,         1,  3,  1,  4,  1, "dual_3_4",      32'hA,        32'hB);
        cyc(0, 0, 0,  32'h0,         1,  4,  1,  3,  1, "dual_swap",     32'hB,        32'hA);
        cyc(0, 0, 0,  32'h0,         1,  3,  1,  3,  1, "dual_same",     32'hA,        32'hA);
        cyc(0, 0, 3,  32'hFFFF,      1,  3,  1,  7,  1, "we0_ignored",   32'hA,        32'h12345678);
        cyc(0, 1, 0,  32'h77,        1,  0,  1,  3,  1, "r0_no_bypass",  32'h0,        32'hA);
        cyc(1, 1, 7,  32'h99,        1,  7,  1,  3,  1, "mid_rst",       32'h0,        32'h0);
        cyc(0, 0, 0,  32'h0,         1,  7,  1,  3,  1, "mid_rst_after", 32'h0,        32'h0);
        cyc(0, 0, 0,  32'h0,         0,  0,  0,  0,  0, "",              32'h0,        32'h0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file for the 5-stage integer pipeline.
- Write end: the single write port receives the write-back triple produced downstream of execute. This is the destination register address, the write enable and the 32-bit result; it commits the result on the clock edge.
- Read end: two read ports supply the decode stage. Those operands return to execute as reg1/reg2.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width; matches `REG_BUS.
- ADDR_W, 5, register address width; matches `REG_ADDR_BUS.
- REG_NUM, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RST_ENABLE = 1), sampled on rising clk.
- we  in  1  write enable (`WRITE_ENABLE = 1); driven by the write-back wreg.
- waddr  in  ADDR_W  destination register; driven by write-back wd.
- wdata  in  DATA_W  write data; driven by write-back wdata.
- re1  in  1  read port 1 enable (`READ_ENABLE = 1).
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data, combinational.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data, combinational.

Behaviour:
- Storage: REG_NUM x DATA_W flops. Entry 0 is never written and always reads `ZERO_DWORD.
- Reset: on a rising clk with rst=1, all entries are cleared to `ZERO_DWORD in that single cycle, and any concurrent write is discarded.
  - While rst=1, rdata1 and rdata2 are `ZERO_DWORD combinationally.
  - First valid write is the rising edge after rst deasserts.
  - Reset asserted mid-stream: pending same-cycle write is lost. Registers hold zero from the next cycle.
- Write: on a rising clk with rst=0, we=1 and waddr!=0, regs[waddr] <= wdata. One-cycle latency, so the value is visible to array reads in the next cycle.
  - we=1 with waddr=0 is a no-op.
  - we=0: waddr and wdata are ignored.
- Read (each port independently, priority order):
  1. rst=1 -> zero.
  2. reN=0 -> zero.
  3. raddrN=0 -> zero.
  4. Bypass hit (see Optional Feature) -> wdata.
  5. Otherwise regs[raddrN].
- Both ports may read the same address simultaneously; both return identical data.
- No X may propagate: unwritten entries read zero after reset.
- Width rules: no extension or truncation; all buses are exactly DATA_W / ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port returns the incoming wdata in the same cycle when all of these hold: rst=0, reN=1, raddrN!=0, we=1 and raddrN==waddr. This is write-to-read forwarding, so a write-back and decode of the same register in one cycle needs no stall.
- Undefined: a read port returns the stored array value (the pre-write value) in that cycle. The new value appears the next cycle; the hazard is resolved by pipeline stalling elsewhere.
- Register 0 is never bypassed in either build.

Decomposition:
- Shared defines file holds these constants:
  - REG_NUM, REG_NUM_LOG2.
  - `READ_ENABLE/`READ_DISABLE, alongside existing `WRITE_ENABLE/`WRITE_DISABLE.
  - `RST_ENABLE, `ZERO_DWORD, `NOP_REG_ADDR, `REG_BUS, `REG_ADDR_BUS.
- One natural sub-module: regfile_rd_port, combinational.
  - Inputs: rst, re, raddr, array word, we, waddr, wdata.
  - Implements the read priority and bypass.
  - Instantiated twice. The write logic and storage array stay in regfile.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst one cycle, deassert; read r5 on both ports -> 0x00000000. With rst=1, any raddr -> 0.
- Basic write/read: we=1, waddr=7, wdata=0x12345678 at edge N; at N+1 re1=1, raddr1=7 -> rdata1=0x12345678; re1=0 -> 0.
- Register 0: we=1, waddr=0, wdata=0xFFFFFFFF; next cycle raddr1=raddr2=0 -> both 0x00000000.
- Same-cycle read/write of r9 (old 0x11111111, new 0x22222222):
  - With REGFILE_BYPASS_EN: rdata1=0x22222222 before the edge.
  - Without: rdata1=0x11111111 before the edge and 0x22222222 after it.
- Dual-port independence: r3=0xA, r4=0xB; raddr1=3, raddr2=4 -> 0xA/0xB. Swap addresses -> 0xB/0xA. Both ports on r3 -> 0xA/0xA.
- Write during reset: rst=1, we=1, waddr=12, wdata=0x55; after deassert, read r12 -> 0x00000000.
